// File: rtl/ibex_branch_predict_bht_if.sv
// Fetch/update/prediction signal bundle for ibex_branch_predict_bht.
// The IF stage side uses the master modport; the predictor uses slave.
interface ibex_branch_predict_bht_if;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_valid_i;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        predict_branch_taken_o;
    logic [31:0] predict_branch_pc_o;
    logic        busy_o;

    modport master (
        output fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        output update_valid_i, update_pc_i, update_taken_i,
        input  predict_branch_taken_o, predict_branch_pc_o, busy_o
    );

    modport slave (
        input  fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        input  update_valid_i, update_pc_i, update_taken_i,
        output predict_branch_taken_o, predict_branch_pc_o, busy_o
    );
endinterface

// File: rtl/ibex_branch_predict_bht.sv
// Dynamic branch predictor: RV32IC branch/jump decode plus a PC-indexed table of
// saturating counters. Optional same-cycle update forwarding via IBEX_BP_BYPASS_EN.
module ibex_branch_predict_bht #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned CNT_INIT    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ibex_branch_predict_bht_if.slave bus
);
    localparam int unsigned      IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT_V = CNT_W'(CNT_INIT);

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q;
    logic [CNT_W-1:0] cnt_q [BHT_ENTRIES];

    logic [31:0] instr;
    logic [31:0] imm_b, imm_j, imm_cj, imm_cb;
    logic [31:0] offset;
    logic        is_branch, is_jump;

    assign instr  = bus.fetch_rdata_i;
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_cj = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
    assign imm_cb = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                     instr[4:3], 1'b0};

    // JALR and C.JR/C.JALR fall through as non-predicted.
    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        offset    = '0;
        if (instr[1:0] == 2'b11) begin
            if (instr[6:0] == 7'h63) begin
                is_branch = 1'b1;
                offset    = imm_b;
            end else if (instr[6:0] == 7'h6f) begin
                is_jump = 1'b1;
                offset  = imm_j;
            end
        end else if (instr[1:0] == 2'b01) begin
            case (instr[15:13])
                3'b001, 3'b101: begin
                    is_jump = 1'b1;
                    offset  = imm_cj;
                end
                3'b110, 3'b111: begin
                    is_branch = 1'b1;
                    offset    = imm_cb;
                end
                default: ;
            endcase
        end
    end

    assign bus.predict_branch_pc_o = bus.fetch_pc_i + offset;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [CNT_W-1:0] upd_cur, upd_next;
    logic             upd_en, lk_msb;
    logic             unused_upd_pc;

    assign lk_idx        = bus.fetch_pc_i[IDX_W:1];
    assign upd_idx       = bus.update_pc_i[IDX_W:1];
    assign unused_upd_pc = ^{bus.update_pc_i[31:IDX_W+1], bus.update_pc_i[0]};
    assign upd_en        = (state_q == RUN) && bus.update_valid_i;
    assign upd_cur       = cnt_q[upd_idx];

    always_comb begin
        upd_next = upd_cur;
        if (bus.update_taken_i) begin
            if (upd_cur != '1) upd_next = upd_cur + CNT_W'(1);
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - CNT_W'(1);
        end
    end

`ifdef IBEX_BP_BYPASS_EN
    assign lk_msb = (upd_en && (upd_idx == lk_idx)) ? upd_next[CNT_W-1] : cnt_q[lk_idx][CNT_W-1];
`else
    assign lk_msb = cnt_q[lk_idx][CNT_W-1];
`endif

    // While the table is being initialised, fall back to backward-taken.
    assign bus.predict_branch_taken_o = bus.fetch_valid_i &
        (is_jump | (is_branch & ((state_q == RUN) ? lk_msb : offset[31])));

    assign bus.busy_o = (state_q == INIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: if (sweep_idx_q == IDX_W'(BHT_ENTRIES - 1)) state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) sweep_idx_q <= sweep_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == INIT) begin
                cnt_q[sweep_idx_q] <= CNT_INIT_V;
            end else if (upd_en) begin
                cnt_q[upd_idx] <= upd_next;
            end
        end
    end
endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Self-checking bench for ibex_branch_predict_bht: directed scenarios plus random
// traffic compared against an arithmetic reference model of the predictor.
module tb_ibex_branch_predict_bht;
    localparam int unsigned BHT  = 64;
    localparam int unsigned CW   = 2;
    localparam int unsigned CI   = 1;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int          HALF = 1 << (CW - 1);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int mcnt [BHT];
    int init_left = 0;

    ibex_branch_predict_bht_if bus ();

    ibex_branch_predict_bht #(
        .BHT_ENTRIES(BHT),
        .CNT_W      (CW),
        .CNT_INIT   (CI)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] off);
        return {off[12], off[10:5], 5'd1, 5'd2, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_cj(input logic [2:0] f3, input logic [31:0] off);
        return {16'h0, f3, off[11], off[4], off[9:8], off[10], off[6], off[7], off[3:1], off[5], 2'b01};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [2:0] f3, input logic [31:0] off);
        return {16'h0, f3, off[8], off[4:3], 3'd2, off[7:6], off[2:1], off[5], 2'b01};
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 1) % BHT);
    endfunction

    function automatic int sat(input int v);
        if (v > CMAX) return CMAX;
        if (v < 0) return 0;
        return v;
    endfunction

    // Reference: decode offsets arithmetically, then apply the prediction rules.
    function automatic void model_predict(output logic taken, output logic [31:0] tgt);
        logic [31:0] in;
        int off, c;
        bit br, jmp;
        in  = bus.fetch_rdata_i;
        off = 0;
        br  = 0;
        jmp = 0;
        if (in[1:0] == 2'b11) begin
            if (in[6:0] == 7'h63) begin
                br  = 1;
                off = (in[31] ? -4096 : 0) + int'(in[7]) * 2048 + int'(in[30:25]) * 32
                      + int'(in[11:8]) * 2;
            end else if (in[6:0] == 7'h6f) begin
                jmp = 1;
                off = (in[31] ? -(1 << 20) : 0) + int'(in[19:12]) * 4096 + int'(in[20]) * 2048
                      + int'(in[30:21]) * 2;
            end
        end else if (in[1:0] == 2'b01) begin
            if (in[15:13] == 3'd1 || in[15:13] == 3'd5) begin
                jmp = 1;
                off = (in[12] ? -2048 : 0) + int'(in[8]) * 1024 + int'(in[10:9]) * 256
                      + int'(in[6]) * 128 + int'(in[7]) * 64 + int'(in[2]) * 32
                      + int'(in[11]) * 16 + int'(in[5:3]) * 2;
            end else if (in[15:13] == 3'd6 || in[15:13] == 3'd7) begin
                br  = 1;
                off = (in[12] ? -256 : 0) + int'(in[6:5]) * 64 + int'(in[2]) * 32
                      + int'(in[11:10]) * 8 + int'(in[4:3]) * 2;
            end
        end
        tgt   = bus.fetch_pc_i + 32'(off);
        taken = 1'b0;
        if (bus.fetch_valid_i) begin
            if (jmp) taken = 1'b1;
            else if (br) begin
                if (init_left > 0) taken = (off < 0);
                else begin
                    c = mcnt[idx_of(bus.fetch_pc_i)];
`ifdef IBEX_BP_BYPASS_EN
                    if (bus.update_valid_i && idx_of(bus.update_pc_i) == idx_of(bus.fetch_pc_i))
                        c = sat(c + (bus.update_taken_i ? 1 : -1));
`endif
                    taken = (c >= HALF);
                end
            end
        end
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
        bus.fetch_rdata_i = inst;
        bus.fetch_pc_i    = pc;
        bus.fetch_valid_i = v;
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t);
        bus.update_valid_i = v;
        bus.update_pc_i    = pc;
        bus.update_taken_i = t;
    endtask

    task automatic step();
        if (rst) begin
            init_left = BHT;
            for (int i = 0; i < BHT; i++) mcnt[i] = CI;
        end else if (init_left > 0) begin
            init_left--;
        end else if (bus.update_valid_i) begin
            mcnt[idx_of(bus.update_pc_i)] = sat(mcnt[idx_of(bus.update_pc_i)] + (bus.update_taken_i ? 1 : -1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input int n);
        for (int i = 0; i < n; i++) begin
            upd(1'b1, pc, t);
            step();
        end
        upd(1'b0, 32'h0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=1", bus.busy_o);
        end
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy_o !== 1'b1) break;
            upd(1'b1, 32'h200, 1'b1);
            if (i == 3) begin
                drive(32'hfe000ee3, 32'h100, 1'b1);
                total++;
                if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h0FC) begin
                    bad++;
                    $display("FAIL init_bwd got=%b/%h exp=1/000000fc", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
                end
            end
            if (i == 4) begin
                drive(enc_b(3'd0, 32'd8), 32'h100, 1'b1);
                total++;
                if (bus.predict_branch_taken_o !== 1'b0 || bus.predict_branch_pc_o !== 32'h108) begin
                    bad++;
                    $display("FAIL init_fwd got=%b/%h exp=0/00000108", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
                end
            end
            busy_cycles++;
            step();
        end
        upd(1'b0, 32'h0, 1'b0);
        total++;
        if (busy_cycles != 64) begin
            bad++;
            $display("FAIL init_len got=%0d exp=64", busy_cycles);
        end
    endtask

    task automatic test_training();
        drive(enc_b(3'd0, 32'd16), 32'h200, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL train_start got=%b exp=0", bus.predict_branch_taken_o);
        end
        train(32'h200, 1'b1, 1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h210) begin
            bad++;
            $display("FAIL train_one got=%b/%h exp=1/00000210", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        train(32'h200, 1'b1, 4);
        train(32'h200, 1'b0, 1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1) begin
            bad++;
            $display("FAIL train_sat_hi got=%b exp=1", bus.predict_branch_taken_o);
        end
        train(32'h200, 1'b0, 1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL train_two_nt got=%b exp=0", bus.predict_branch_taken_o);
        end
        train(32'h200, 1'b0, 3);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL train_sat_lo got=%b exp=0", bus.predict_branch_taken_o);
        end
        train(32'h200, 1'b1, 1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL train_back_one got=%b exp=0", bus.predict_branch_taken_o);
        end
    endtask

    task automatic test_jumps();
        drive(enc_j(32'd2048), 32'hFFFF_F800, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL jal_wrap got=%b/%h exp=1/00000000", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(enc_j(32'd2048), 32'hFFFF_F800, 1'b0);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0 || bus.predict_branch_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL jal_invalid got=%b/%h exp=0/00000000", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(enc_cj(3'd5, 32'hFFFF_FFFE), 32'h10, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h0E) begin
            bad++;
            $display("FAIL cj_back got=%b/%h exp=1/0000000e", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(enc_cj(3'd1, 32'h2A4), 32'h1000, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h12A4) begin
            bad++;
            $display("FAIL cjal got=%b/%h exp=1/000012a4", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(32'h010080e7, 32'h500, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0 || bus.predict_branch_pc_o !== 32'h500) begin
            bad++;
            $display("FAIL jalr got=%b/%h exp=0/00000500", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(32'h0000_8082, 32'h504, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL cjr got=%b exp=0", bus.predict_branch_taken_o);
        end
    endtask

    task automatic test_compressed();
        train(32'h402, 1'b1, 2);
        drive(enc_cb(3'd7, 32'd6), 32'h402, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h408) begin
            bad++;
            $display("FAIL cbnez got=%b/%h exp=1/00000408", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
        drive(enc_cb(3'd6, 32'hFFFF_FF00), 32'h402, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1 || bus.predict_branch_pc_o !== 32'h302) begin
            bad++;
            $display("FAIL cbeqz got=%b/%h exp=1/00000302", bus.predict_branch_taken_o, bus.predict_branch_pc_o);
        end
    endtask

    task automatic test_collision();
        logic exp_t;
`ifdef IBEX_BP_BYPASS_EN
        exp_t = 1'b1;
`else
        exp_t = 1'b0;
`endif
        // entry 0 sits at 1 after the training sequence
        upd(1'b1, 32'h300, 1'b1);
        drive(enc_b(3'd1, 32'd16), 32'h300, 1'b1);
        total++;
        if (bus.predict_branch_taken_o !== exp_t) begin
            bad++;
            $display("FAIL same_cycle got=%b exp=%b", bus.predict_branch_taken_o, exp_t);
        end
        step();
        upd(1'b0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.predict_branch_taken_o !== 1'b1) begin
            bad++;
            $display("FAIL after_update got=%b exp=1", bus.predict_branch_taken_o);
        end
        train(32'h380, 1'b0, 2);
        total++;
        if (bus.predict_branch_taken_o !== 1'b0) begin
            bad++;
            $display("FAIL alias_down got=%b exp=0", bus.predict_branch_taken_o);
        end
        train(32'h380, 1'b1, 2);
        total++;
        if (bus.predict_branch_taken_o !== 1'b1) begin
            bad++;
            $display("FAIL alias_up got=%b exp=1", bus.predict_branch_taken_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] inst, pc, etgt;
        logic        et;
        int          off;
        for (int i = 0; i < 8; i++) pool[i] = 32'((i * 6 + 2) * 2) + 32'h1000 * 32'(i);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0: begin off = int'($urandom_range(0, 4095)) * 2 - 4096;
                         inst = enc_b(3'($urandom_range(0, 7)), 32'(off)); end
                1: begin off = int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20);
                         inst = enc_j(32'(off)); end
                2: begin off = int'($urandom_range(0, 2047)) * 2 - 2048;
                         inst = enc_cj($urandom_range(0, 1) != 0 ? 3'd5 : 3'd1, 32'(off)); end
                3: begin off = int'($urandom_range(0, 255)) * 2 - 256;
                         inst = enc_cb($urandom_range(0, 1) != 0 ? 3'd7 : 3'd6, 32'(off)); end
                4: inst = {$urandom() & 32'hFFFF_FF80} | 32'h67;
                5: inst = {$urandom() & 32'hFFFF_FF80} | 32'h13;
                default: inst = $urandom();
            endcase
            pc = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : ($urandom() & 32'hFFFF_FFFE);
            upd($urandom_range(0, 1) != 0, pool[$urandom_range(0, 7)], $urandom_range(0, 2) != 0);
            drive(inst, pc, $urandom_range(0, 7) != 0);
            model_predict(et, etgt);
            total++;
            if (bus.predict_branch_taken_o !== et || bus.predict_branch_pc_o !== etgt) begin
                bad++;
                $display("FAIL random n=%0d inst=%h pc=%h got=%b/%h exp=%b/%h", n, inst, pc,
                         bus.predict_branch_taken_o, bus.predict_branch_pc_o, et, etgt);
            end
            total++;
            if (bus.busy_o !== (init_left > 0)) begin
                bad++;
                $display("FAIL random_busy n=%0d got=%b exp=%b", n, bus.busy_o, init_left > 0);
            end
            step();
        end
        upd(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int busy_cycles;
        logic exp_t;
        exp_t = ((CI >> (CW - 1)) & 1) != 0;
        train(32'h200, 1'b1, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy_o !== 1'b1) break;
            upd(1'b1, 32'(($urandom_range(0, BHT - 1)) * 2), 1'b1);
            busy_cycles++;
            step();
        end
        upd(1'b0, 32'h0, 1'b0);
        total++;
        if (busy_cycles != 64) begin
            bad++;
            $display("FAIL mid_init_len got=%0d exp=64", busy_cycles);
        end
        for (int e = 0; e < BHT; e++) begin
            drive(enc_b(3'd0, 32'd8), 32'(e * 2), 1'b1);
            total++;
            if (bus.predict_branch_taken_o !== exp_t) begin
                bad++;
                $display("FAIL post_init entry=%0d got=%b exp=%b", e, bus.predict_branch_taken_o, exp_t);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.fetch_rdata_i  = '0;
        bus.fetch_pc_i     = '0;
        bus.fetch_valid_i  = 1'b0;
        bus.update_valid_i = 1'b0;
        bus.update_pc_i    = '0;
        bus.update_taken_i = 1'b0;
        test_reset();
        test_training();
        test_jumps();
        test_compressed();
        test_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
